// File: rtl/reg_hazard_ctrl.sv
// Hazard/forwarding controller for the register file: EX/WB destination tracking,
// MDU R0 sequencing, write-port controls and decode stall. Define HAZ_PERF_EN to add stall_count.
module reg_hazard_ctrl #(
  parameter int         REG_NUM_WIDTH        = 4,
  parameter int         NUM_REG              = 16,
  parameter int         MDU_LATENCY          = 4,
  parameter logic [1:0] REG_FORWARD_REG_FILE = 2'b00,
  parameter logic [1:0] REG_FORWARD_WB       = 2'b01,
  parameter logic [1:0] REG_FORWARD_R0       = 2'b10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [REG_NUM_WIDTH-1:0] id_rn_1,
  input  logic [REG_NUM_WIDTH-1:0] id_rn_2,
  input  logic                     id_use_1,
  input  logic                     id_use_2,
  input  logic [REG_NUM_WIDTH-1:0] id_wrn,
  input  logic                     id_wr,
  input  logic                     id_mdu,
  input  logic                     flush,
  output logic [1:0]               reg_forward_1,
  output logic [1:0]               reg_forward_2,
  output logic                     stall,
  output logic                     wr,
  output logic [REG_NUM_WIDTH-1:0] wrn,
  output logic                     wr0,
  output logic                     exception,
`ifdef HAZ_PERF_EN
  output logic [15:0]              stall_count,
`endif
  output logic [1:0]               mdu_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} mdu_state_t;

  localparam logic [3:0]               CNT_LOAD  = 4'(MDU_LATENCY - 2);
  localparam logic [REG_NUM_WIDTH:0]   NUM_REG_L = (REG_NUM_WIDTH + 1)'(NUM_REG);

  logic                     ex_valid, ex_wr, wb_valid, wb_wr, exc;
  logic [REG_NUM_WIDTH-1:0] ex_wrn, wb_wrn;
  mdu_state_t               state, state_next;
  logic [3:0]               cnt, cnt_next;

  logic hit_1, hit_2, haz_1, haz_2, accept, illegal_wrn;

  assign hit_1 = id_valid & id_use_1;
  assign hit_2 = id_valid & id_use_2;
  // An EX result is not yet available to forward; R0 is unknown while the MDU is busy.
  assign haz_1 = hit_1 & ((ex_valid & ex_wr & (ex_wrn == id_rn_1)) |
                          ((id_rn_1 == '0) & (state == BUSY)));
  assign haz_2 = hit_2 & ((ex_valid & ex_wr & (ex_wrn == id_rn_2)) |
                          ((id_rn_2 == '0) & (state == BUSY)));

  assign stall       = !rst & id_valid & !flush & (haz_1 | haz_2 | (id_mdu & (state == BUSY)));
  assign accept      = id_valid & !stall & !flush;
  assign illegal_wrn = ({1'b0, id_wrn} >= NUM_REG_L);

  assign wr        = !rst & wb_valid & wb_wr;
  assign wrn       = rst ? '0 : wb_wrn;
  assign wr0       = !rst & (state == DONE);
  assign exception = exc;
  assign mdu_state = state;

  // The MDU result outranks a same-cycle WB write of R0, matching reg_file write order.
  assign reg_forward_1 = (rst || !hit_1)                      ? REG_FORWARD_REG_FILE :
                         ((id_rn_1 == '0) && (state == DONE)) ? REG_FORWARD_R0 :
                         (wr && (wrn == id_rn_1))             ? REG_FORWARD_WB :
                                                                REG_FORWARD_REG_FILE;
  assign reg_forward_2 = (rst || !hit_2)                      ? REG_FORWARD_REG_FILE :
                         ((id_rn_2 == '0) && (state == DONE)) ? REG_FORWARD_R0 :
                         (wr && (wrn == id_rn_2))             ? REG_FORWARD_WB :
                                                                REG_FORWARD_REG_FILE;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_wr    <= 1'b0;
      ex_wrn   <= '0;
      wb_valid <= 1'b0;
      wb_wr    <= 1'b0;
      wb_wrn   <= '0;
      exc      <= 1'b0;
    end else begin
      wb_valid <= ex_valid;
      wb_wr    <= ex_wr;
      wb_wrn   <= ex_wrn;
      ex_valid <= accept;
      ex_wr    <= accept & id_wr & !illegal_wrn;
      ex_wrn   <= accept ? id_wrn : '0;
      if (accept && id_wr && illegal_wrn) exc <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept && id_mdu) begin
          state_next = BUSY;
          cnt_next   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt == '0) state_next = DONE;
        else           cnt_next   = cnt - 4'd1;
      end
      DONE: begin
        if (accept && id_mdu) begin
          state_next = BUSY;
          cnt_next   = CNT_LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef HAZ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst)                                 stall_count <= '0;
    else if (stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
  end
`endif

endmodule

// File: doc/reg_hazard_ctrl.md
Name: reg_hazard_ctrl

Overview:
- Pipeline hazard and forwarding controller for the 16-entry register file.
- Tracks in-flight destination registers through EX and WB, and a multi-cycle multiply/divide unit (MDU) that writes R0.
- Generates the per-port forward selects, the write-port controls (wr, wrn, wr0) and the decode stall.
- Sits between decode and reg_file; the instruction is held in ID while stall is high.

Parameters:
- REG_NUM_WIDTH, 4, register-number width.
- NUM_REG, 16, number of architectural registers.
- MDU_LATENCY, 4, cycles from MDU issue to the R0 write; legal range 2..15.
- REG_FORWARD_REG_FILE, 2'b00, select: read from array.
- REG_FORWARD_WB, 2'b01, select: forward WB write data.
- REG_FORWARD_R0, 2'b10, select: forward MDU R0 data.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a valid instruction.
- id_rn_1, id_rn_2  in  REG_NUM_WIDTH  source register numbers.
- id_use_1, id_use_2  in  1  the corresponding source is actually read.
- id_wrn  in  REG_NUM_WIDTH  destination register.
- id_wr  in  1  instruction writes id_wrn.
- id_mdu  in  1  instruction is an MDU op; result goes to R0.
- flush  in  1  kill the ID instruction (taken branch).
- reg_forward_1, reg_forward_2  out  2  forward select per read port.
- stall  out  1  hold ID/IF this cycle.
- wr  out  1  register-file write enable (WB stage).
- wrn  out  REG_NUM_WIDTH  register-file write number.
- wr0  out  1  MDU R0 write strobe.
- exception  out  1  sticky: illegal destination register.

Behaviour:
- Internal state:
  - EX slot {ex_valid, ex_wr, ex_wrn} and WB slot {wb_valid, wb_wr, wb_wrn}.
  - MDU FSM with states IDLE, BUSY, DONE, plus a down-counter cnt.
  - Sticky exception flag.
- Reset (rst=1 at an edge):
  - All slots invalid, FSM to IDLE, cnt=0, exception=0.
  - Outputs during and after reset: stall=0, wr=0, wrn=0, wr0=0, both forward selects 00.
- Reset mid-MDU op aborts the op; wr0 is never asserted for it.
- Outputs:
  - wr = wb_valid & wb_wr; wrn = wb_wrn.
  - wr0 = 1 exactly while the FSM is in DONE.
- Source match for port k: hit_k = id_valid & id_use_k.
- Stall (combinational) = id_valid & !flush & any of:
  - (a) hit_k with ex_valid & ex_wr & ex_wrn == id_rn_k (EX result not forwardable).
  - (b) hit_k with id_rn_k == 0 and FSM == BUSY.
  - (c) id_mdu with FSM == BUSY.
- Forward select per port, in priority order:
  - REG_FORWARD_R0 if hit_k, id_rn_k == 0 and FSM == DONE.
  - else REG_FORWARD_WB if hit_k & wr & wrn == id_rn_k.
  - else REG_FORWARD_REG_FILE.
  - When hit_k = 0 the select is 00.
- Pipeline advance every cycle:
  - WB <= EX.
  - If stall or flush or !id_valid, EX <= bubble (ex_valid=0); else EX <= {1, id_wr, id_wrn}.
- Accept = id_valid & !stall & !flush.
- MDU FSM:
  - IDLE: on accept & id_mdu, cnt <= MDU_LATENCY-2 and go to BUSY.
  - BUSY: if cnt == 0 go to DONE, else cnt <= cnt-1.
  - DONE: lasts one cycle. On accept & id_mdu, back-to-back reissue (cnt <= MDU_LATENCY-2, go to BUSY); else go to IDLE.
  - Net timing: an MDU op accepted at cycle t gives wr0=1 at cycle t+MDU_LATENCY.
- Flush does not cancel an in-flight MDU op; it only suppresses the issue in ID.
- Simultaneous R0 write from WB (wr & wrn == 0) and wr0: the MDU result wins (reg_file applies wr0 last), and the ID forward select is R0.
- Exception: set when accept & id_wr & id_wrn >= NUM_REG.
  - That instruction enters EX with ex_wr forced to 0.
  - Cleared only by rst.

Optional Feature:
- HAZ_PERF_EN: when defined, adds output stall_count [15:0].
  - Increments on every cycle with stall=1, saturating at 16'hFFFF.
  - Cleared by rst.
- Without the macro the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=1 for 2 cycles while id_valid=1, id_mdu=1 -> stall=0, wr=0, wr0=0, selects 00; no MDU op starts.
- EX hazard: cycle 0 issue id_wr=1, id_wrn=5; cycle 1 ID reads id_rn_1=5 -> stall=1 in cycle 1; cycle 2: stall=0, reg_forward_1=01, wr=1, wrn=5.
- MDU with MDU_LATENCY=4: issue at cycle 0; read R0 at cycles 1-3 -> stall=1 at 1-3; cycle 4: wr0=1, reg_forward=10, stall=0.
- Back-to-back MDU: second id_mdu is held while BUSY and accepted in DONE at cycle 4 -> wr0 pulses at cycles 4 and 8 only.
- Flush: flush=1 with id_mdu=1, id_wr=1, id_wrn=3 -> FSM stays IDLE; two cycles later wr=0.
- Reset mid-op: rst at cycle 2 of a 4-cycle MDU op -> wr0 never asserts; FSM is IDLE at cycle 3. With NUM_REG=8, accept id_wrn=9 -> exception=1 persists, and wr=0 two cycles later.
